// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with a small byte FIFO.
//
// Bytes enter over a valid/ready handshake into a circular buffer and are sent LSB first,
// one start bit (low), eight data bits, one stop bit (high), each CLKS_PER_BIT cycles long.
// When the FIFO still holds data at the end of a stop bit, the next start bit follows
// immediately, with no idle gap between frames.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset; abandons any frame and flushes the FIFO
//   tx_data     byte to enqueue
//   tx_valid    tx_data valid this cycle
//   tx_ready    FIFO can accept a byte (count register not full)
//   tx          registered serial output, idle high
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes currently queued, 0..FIFO_DEPTH
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [BaudW-1:0]  baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];

   logic       push;
   logic       pop;
   logic       baud_done;
   logic       fifo_empty;
   logic [7:0] head;

   // Ready depends only on the count register, so a pop on the same edge never frees a slot
   // for a push that arrives while full.
   assign tx_ready   = (count_q != CntFull);
   assign push       = tx_valid && tx_ready;
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign baud_done  = (baud_q == BaudLast);

   assign tx         = tx_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;
   assign fifo_count = count_q;

   // Serialiser FSM; also decides when the head byte is popped.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end

         StStart: begin
            if (baud_done) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
               state_d   = StData;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         StData: begin
            if (baud_done) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  // Next bit is shift_q[1]; present it on the same edge as the shift.
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         StStop: begin
            if (baud_done) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  // Chain straight into the next start bit.
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   // FIFO pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a vector table for reset and the first frame,
// a frame-level reference model compared every cycle, a serial decoder on tx, and a
// second default-parameter instance decoded as a loopback receiver.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   localparam int CPB_B = 87;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_line;
   logic       busy;
   logic [2:0] fifo_count;

   logic [7:0] data_b;
   logic       valid_b;
   logic       ready_b;
   logic       tx_b;
   logic       busy_b;
   logic [2:0] count_b;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx_line),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   uart_tx_fifo dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (data_b),
      .tx_valid   (valid_b),
      .tx_ready   (ready_b),
      .tx         (tx_b),
      .busy       (busy_b),
      .fifo_count (count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus the position inside the current frame (-1 = idle).
   logic [7:0] mq[$];
   int         fpos = -1;
   logic [7:0] cur = 8'h00;
   bit         acc = 1'b0;

   task automatic model_step();
      bit pop;
      acc = 1'b0;
      if (!rst_n) begin
         mq.delete();
         fpos = -1;
      end else begin
         pop = (mq.size() != 0) && (fpos < 0 || fpos == FRAME - 1);
         acc = tx_valid && (mq.size() < DEPTH);
         if (pop) begin
            cur  = mq.pop_front();
            fpos = 0;
         end else if (fpos == FRAME - 1) begin
            fpos = -1;
         end else if (fpos >= 0) begin
            fpos++;
         end
         if (acc) mq.push_back(tx_data);
      end
   endtask

   function automatic logic exp_tx();
      int b;
      if (fpos < 0) return 1'b1;
      b = fpos / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return cur[b-1];
   endfunction

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tx", tx_line, exp_tx());
      chk("fifo_count", fifo_count, mq.size());
      chk("busy", busy, (fpos >= 0) || (mq.size() != 0));
      chk("tx_ready", tx_ready, mq.size() != DEPTH);
   endtask

   // Independent serial decoders, sampling mid-bit; stored as {stop, byte}.
   bit         rx_en = 1'b0;
   logic [8:0] rxq[$];
   logic [8:0] rxq_b[$];

   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && tx_line === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx_line;
            end
            repeat (CPB) @(negedge clk);
            rxq.push_back({tx_line, b});
         end
      end
   end

   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && tx_b === 1'b0) begin
            repeat (CPB_B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB_B) @(negedge clk);
               b[i] = tx_b;
            end
            repeat (CPB_B) @(negedge clk);
            rxq_b.push_back({tx_b, b});
         end
      end
   end

   logic [7:0] exp_q[$];

   task automatic load_range(input logic [7:0] first, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
   endtask

   // Push every byte of exp_q, advancing only when the model says the byte was taken.
   task automatic push_seq(input string name);
      int i = 0;
      int g = 0;
      while (i < exp_q.size() && g < 2000) begin
         tx_valid = 1'b1;
         tx_data  = exp_q[i];
         cycle();
         if (acc) i++;
         g++;
      end
      tx_valid = 1'b0;
      chk({name, "_push_timeout"}, 32'(g < 2000), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while ((fpos >= 0 || mq.size() != 0) && g < 2000) begin
         cycle();
         g++;
      end
      chk({name, "_idle_timeout"}, 32'(g < 2000), 32'd1);
      repeat (4) cycle();
   endtask

   task automatic check_rx(input string name, input bit which);
      int n;
      n = which ? rxq_b.size() : rxq.size();
      chk({name, "_rx_len"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         chk({name, "_rx_byte"}, which ? rxq_b[i] : rxq[i], {1'b1, exp_q[i]});
      end
   endtask

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] dat;
      int         cnt;
      logic       rdy;
      logic       txv;
      logic       bsy;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int k;
      int g;
      int cnt_before;

      // Reset with a push attempt, then push 0xA5 (edge N = entry 2), first frame cycles.
      vecs[0]  = '{1'b0, 1'b1, 8'h77, 0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};

      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      valid_b  = 1'b0;
      data_b   = 8'h00;

      // Test 1: single byte
      for (int i = 0; i < 12; i++) begin
         rst_n    = vecs[i].rst;
         tx_valid = vecs[i].vld;
         tx_data  = vecs[i].dat;
         cycle();
         chk("vec_count", fifo_count, vecs[i].cnt);
         chk("vec_ready", tx_ready, vecs[i].rdy);
         chk("vec_tx", tx_line, vecs[i].txv);
         chk("vec_busy", busy, vecs[i].bsy);
         if (i == 0) begin
            rx_en = 1'b1;
            rxq.delete();
            rxq_b.delete();
         end
      end
      tx_valid = 1'b0;
      k = 9;
      while (busy && k < 200) begin
         cycle();
         k++;
      end
      chk("busy_fall_edge", k, 41);
      repeat (4) cycle();
      exp_q.delete();
      exp_q.push_back(8'hA5);
      check_rx("single", 1'b0);

      // Test 2: burst fill, contiguous frames
      rxq.delete();
      load_range(8'h01, 6);
      push_seq("burst");
      wait_idle("burst");
      check_rx("burst", 1'b0);

      // Test 3: push refused while full even on a pop edge
      rxq.delete();
      load_range(8'h20, 5);
      push_seq("full");
      chk("full_count", fifo_count, 4);
      g = 0;
      cnt_before = 0;
      acc = 1'b0;
      while (!acc && g < 400) begin
         cnt_before = 32'(fifo_count);
         tx_valid   = 1'b1;
         tx_data    = 8'hFF;
         cycle();
         g++;
      end
      tx_valid = 1'b0;
      chk("refuse_count_before_accept", cnt_before, 3);
      chk("accept_count", fifo_count, 4);
      exp_q.push_back(8'hFF);
      wait_idle("full");
      check_rx("full", 1'b0);

      // Test 4: reset during data bit 3 with two bytes queued
      rxq.delete();
      load_range(8'h40, 3);
      push_seq("rst");
      g = 0;
      while (fpos != 17 && g < 200) begin
         cycle();
         g++;
      end
      chk("rst_reach_bit3", 32'(g < 200), 32'd1);
      chk("rst_queued", fifo_count, 2);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("rst_tx", tx_line, 1'b1);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", tx_ready, 1'b1);
      repeat (50) cycle();
      rxq.delete();
      repeat (2 * FRAME) cycle();
      chk("rst_no_frames", rxq.size(), 0);
      exp_q.delete();
      exp_q.push_back(8'h3C);
      push_seq("rst_after");
      wait_idle("rst_after");
      check_rx("rst_after", 1'b0);

      // Test 5: pointer wrap
      rxq.delete();
      load_range(8'h10, 9);
      push_seq("wrap");
      wait_idle("wrap");
      check_rx("wrap", 1'b0);

      // Extra: random bytes and gaps against the model
      rxq.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         tx_valid = ($urandom_range(0, 2) != 0);
         tx_data  = 8'($urandom);
         cycle();
         if (acc) exp_q.push_back(tx_data);
      end
      tx_valid = 1'b0;
      wait_idle("random");
      check_rx("random", 1'b0);

      // Test 6: loopback at default parameters
      exp_q.delete();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'hFF);
      rxq_b.delete();
      for (int i = 0; i < 4; i++) begin
         valid_b = 1'b1;
         data_b  = exp_q[i];
         cycle();
      end
      valid_b = 1'b0;
      g = 0;
      while (busy_b && g < 5000) begin
         cycle();
         g++;
      end
      chk("loop_idle_timeout", 32'(g < 5000), 32'd1);
      repeat (4) cycle();
      check_rx("loopback", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
